// File: rtl/result_frame_stats.sv
// result_frame_stats: gathers signed rule-unit results into frames and
// reports each frame's sum, maximum, minimum and sample count over a
// valid/ready handshake. The producer is stalled while a result is pending.
module result_frame_stats #(
    parameter int DATA_W    = 10,
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = DATA_W + $clog2(FRAME_LEN),
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [SUM_W-1:0]  out_sum,
    output logic signed [DATA_W-1:0] out_max,
    output logic signed [DATA_W-1:0] out_min,
    output logic        [CNT_W-1:0]  out_cnt
);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t state, state_nxt;

    logic signed [SUM_W-1:0]  sum_acc, sum_nxt;
    logic signed [DATA_W-1:0] max_acc, max_nxt;
    logic signed [DATA_W-1:0] min_acc, min_nxt;
    logic        [CNT_W-1:0]  cnt_acc, cnt_nxt;
    logic                     accept;

    // Sign-extend a sample to accumulator width (works even when SUM_W == DATA_W).
    function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        logic signed [SUM_W-1:0] r;
        r = x;
        return r;
    endfunction

    assign accept = in_valid & in_ready;

    // Running frame statistics including the sample being accepted this cycle.
    always_comb begin
        sum_nxt = sum_acc;
        max_nxt = max_acc;
        min_nxt = min_acc;
        cnt_nxt = cnt_acc;
        if (accept) begin
            if (state == IDLE) begin
                sum_nxt = sext(in_data);
                max_nxt = in_data;
                min_nxt = in_data;
                cnt_nxt = CNT_W'(1);
            end else begin
                sum_nxt = sum_acc + sext(in_data);
                if (in_data > max_acc) max_nxt = in_data;
                if (in_data < min_acc) min_nxt = in_data;
                cnt_nxt = cnt_acc + CNT_W'(1);
            end
        end
    end

    // Next-state logic: close the frame when it fills or on flush.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (FRAME_LEN == 1 || flush) state_nxt = HOLD;
                    else                         state_nxt = ACC;
                end
            end
            ACC: begin
                if (flush || (accept && cnt_nxt == CNT_W'(FRAME_LEN)))
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake flags follow the next state so they are registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt != HOLD);
            out_valid <= (state_nxt == HOLD);
        end
    end

    // Result registers capture the closed frame on HOLD entry and then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_sum <= '0;
            out_max <= '0;
            out_min <= '0;
            out_cnt <= '0;
        end else if (state != HOLD && state_nxt == HOLD) begin
            out_sum <= sum_nxt;
            out_max <= max_nxt;
            out_min <= min_nxt;
            out_cnt <= cnt_nxt;
        end
    end

    // Accumulators need no reset: the first accepted sample in IDLE reloads them.
    always_ff @(posedge clk) begin
        sum_acc <= sum_nxt;
        max_acc <= max_nxt;
        min_acc <= min_nxt;
        cnt_acc <= cnt_nxt;
    end

endmodule
